// File: rtl/vx_dma_arb_if.sv
// Interface bundling the requester-side and engine-side handshakes of the
// DMA arbiter, plus its status outputs.
// Handshake rule (every channel): a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised, the sender holds
// valid and its payload steady until that transfer.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding requesters and engine.
interface vx_dma_arb_if #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int MAX_PENDING = 8
);
    localparam int ETAG_W = $clog2(MAX_PENDING);
    localparam int PCNT_W = $clog2(MAX_PENDING) + 1;

    // requester request channel
    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0]            req_ready;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_src_addr;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_dst_addr;
    logic [NUM_REQS*SIZE_WIDTH-1:0] req_size;
    logic [NUM_REQS-1:0]            req_to_lmem;
    logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
    // requester completion channel
    logic [NUM_REQS-1:0]            rsp_valid;
    logic [NUM_REQS-1:0]            rsp_ready;
    logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_tag;
    // engine request channel
    logic                           eng_req_valid;
    logic                           eng_req_ready;
    logic [ADDR_WIDTH-1:0]          eng_req_src_addr;
    logic [ADDR_WIDTH-1:0]          eng_req_dst_addr;
    logic [SIZE_WIDTH-1:0]          eng_req_size;
    logic                           eng_req_to_lmem;
    logic [ETAG_W-1:0]              eng_req_tag;
    // engine completion channel
    logic                           eng_rsp_valid;
    logic                           eng_rsp_ready;
    logic [ETAG_W-1:0]              eng_rsp_tag;
    // status
    logic [PCNT_W-1:0]              pending_count;
    logic                           tag_err;
    logic [31:0]                    perf_stall_cycles;

    modport slave (
        input  req_valid, req_src_addr, req_dst_addr, req_size, req_to_lmem, req_tag,
        output req_ready,
        output rsp_valid, rsp_tag,
        input  rsp_ready,
        output eng_req_valid, eng_req_src_addr, eng_req_dst_addr, eng_req_size,
        output eng_req_to_lmem, eng_req_tag,
        input  eng_req_ready,
        input  eng_rsp_valid, eng_rsp_tag,
        output eng_rsp_ready,
        output pending_count, tag_err, perf_stall_cycles
    );

    modport master (
        output req_valid, req_src_addr, req_dst_addr, req_size, req_to_lmem, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_tag,
        output rsp_ready,
        input  eng_req_valid, eng_req_src_addr, eng_req_dst_addr, eng_req_size,
        input  eng_req_to_lmem, eng_req_tag,
        output eng_req_ready,
        output eng_rsp_valid, eng_rsp_tag,
        input  eng_rsp_ready,
        input  pending_count, tag_err, perf_stall_cycles
    );
endinterface

// File: rtl/vx_dma_arb.sv
// vx_dma_arb: shares one DMA engine among NUM_REQS requesters.
// A round-robin grant picks one requester. Its request passes straight to the
// engine, tagged with the lowest free slot of a MAX_PENDING-entry table. That
// table remembers which requester and which requester tag own each slot, so
// engine completions can be routed back with no added latency.
// Optional feature: define DMA_ARB_PERF_EN to build the stall-cycle counter.
// When the macro is undefined, perf_stall_cycles is tied to zero.
module vx_dma_arb #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int MAX_PENDING = 8
) (
    input  logic        clk,
    input  logic        reset,
    vx_dma_arb_if.slave bus
);
    localparam int ETAG_W = $clog2(MAX_PENDING);
    localparam int PCNT_W = $clog2(MAX_PENDING) + 1;
    localparam int RID_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    // slot table and arbitration state
    logic [MAX_PENDING-1:0] slot_valid_q;
    logic [RID_W-1:0]       slot_id_q  [MAX_PENDING];
    logic [TAG_WIDTH-1:0]   slot_tag_q [MAX_PENDING];
    logic [RID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PCNT_W-1:0]      pending_q, pending_d;
    logic                   tag_err_q;

    logic                   any_valid;
    logic [RID_W-1:0]       grant_idx;
    logic                   free_found;
    logic [ETAG_W-1:0]      free_idx;
    logic                   full;
    logic                   req_fire;
    logic                   rsp_hit;
    logic [RID_W-1:0]       rsp_id;
    logic                   rsp_fire;
    logic                   rsp_err;

    // Round-robin grant: first asserted req_valid at or after rr_ptr.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQS;
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = RID_W'(idx);
            end
        end
    end

    // Lowest free slot. Uses the registered valid vector, so a slot freed
    // this cycle only becomes allocatable on the next cycle.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int s = 0; s < MAX_PENDING; s++) begin
            if (!free_found && !slot_valid_q[s]) begin
                free_found = 1'b1;
                free_idx   = ETAG_W'(s);
            end
        end
    end

    assign full = &slot_valid_q;

    // Request pass-through: payload is muxed from the granted requester.
    always_comb begin
        bus.eng_req_valid    = any_valid && !full && !reset;
        bus.eng_req_src_addr = bus.req_src_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        bus.eng_req_dst_addr = bus.req_dst_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        bus.eng_req_size     = bus.req_size[grant_idx*SIZE_WIDTH +: SIZE_WIDTH];
        bus.eng_req_to_lmem  = bus.req_to_lmem[grant_idx];
        bus.eng_req_tag      = free_idx;
        req_fire             = bus.eng_req_valid && bus.eng_req_ready;
        bus.req_ready        = '0;
        bus.req_ready[grant_idx] = req_fire;
    end

    // Response routing: the engine tag indexes the slot table directly.
    // A tag for an empty slot is accepted and dropped, and it raises tag_err.
    always_comb begin
        rsp_hit           = slot_valid_q[bus.eng_rsp_tag];
        rsp_id            = slot_id_q[bus.eng_rsp_tag];
        bus.rsp_valid     = '0;
        bus.rsp_tag       = '0;
        bus.eng_rsp_ready = 1'b1;
        if (rsp_hit) begin
            bus.rsp_valid[rsp_id] = bus.eng_rsp_valid && !reset;
            bus.rsp_tag[rsp_id*TAG_WIDTH +: TAG_WIDTH] = slot_tag_q[bus.eng_rsp_tag];
            bus.eng_rsp_ready = bus.rsp_ready[rsp_id];
        end
        rsp_fire = bus.eng_rsp_valid && bus.eng_rsp_ready && rsp_hit;
        rsp_err  = bus.eng_rsp_valid && !rsp_hit;
    end

    // Next-state values for the arbitration pointer and the occupancy count.
    always_comb begin
        rr_ptr_d  = req_fire ? RID_W'((int'(grant_idx) + 1) % NUM_REQS) : rr_ptr_q;
        pending_d = pending_q + PCNT_W'(req_fire) - PCNT_W'(rsp_fire);
    end

    // Slot table, pointer, count and sticky error update.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_q <= '0;
            for (int s = 0; s < MAX_PENDING; s++) begin
                slot_id_q[s]  <= '0;
                slot_tag_q[s] <= '0;
            end
            rr_ptr_q  <= '0;
            pending_q <= '0;
            tag_err_q <= 1'b0;
        end else begin
            if (req_fire) begin
                slot_valid_q[free_idx] <= 1'b1;
                slot_id_q[free_idx]    <= grant_idx;
                slot_tag_q[free_idx]   <= bus.req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
            end
            if (rsp_fire) begin
                slot_valid_q[bus.eng_rsp_tag] <= 1'b0;
            end
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            if (rsp_err) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign bus.pending_count = pending_q;
    assign bus.tag_err       = tag_err_q;

`ifdef DMA_ARB_PERF_EN
    logic [31:0] perf_q;
    logic        stall;

    assign stall = any_valid && !req_fire;

    // Saturating count of cycles where someone waits and nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (stall && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = perf_q;
`else
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_vx_dma_arb.sv
// Directed testbench for vx_dma_arb with default parameters (4 requesters,
// 8 slots). Inputs change 1ns after each rising edge. Outputs are checked
// 1ns after that, well before the next edge.
module tb_vx_dma_arb;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int TW = 4;
    localparam int MP = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vx_dma_arb_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                    .TAG_WIDTH(TW), .MAX_PENDING(MP)) bus ();

    vx_dma_arb #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                 .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid     = '0;
        bus.rsp_ready     = '0;
        bus.eng_req_ready = 1'b0;
        bus.eng_rsp_valid = 1'b0;
        bus.eng_rsp_tag   = '0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Fixed per-requester payloads: src 0x1000+i, dst 0x2000+i, size 0x10*(i+1),
    // to_lmem = bit 0 of i, tag 0x8+i (requester 2 carries 0xA).
    task automatic set_payloads();
        for (int i = 0; i < NR; i++) begin
            bus.req_src_addr[i*AW +: AW] = 32'h1000 + i;
            bus.req_dst_addr[i*AW +: AW] = 32'h2000 + i;
            bus.req_size[i*SW +: SW]     = 16'(16 * (i + 1));
            bus.req_to_lmem[i]           = i[0];
            bus.req_tag[i*TW +: TW]      = 4'(8 + i);
        end
    endtask

    // driver: requester r issues n requests back to back, engine always ready
    task automatic fill(input int r, input int n);
        bus.req_valid     = 4'(1 << r);
        bus.eng_req_ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
        bus.req_valid     = '0;
        bus.eng_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.req_valid     = 4'hF;
        bus.eng_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.eng_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_eng_valid got %b exp 0", bus.eng_req_valid);
        end
        checks++;
        if (bus.req_ready !== 4'h0) begin
            errors++; $display("FAIL reset_req_ready got %h exp 0", bus.req_ready);
        end
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pending_count !== 4'd0) begin
            errors++; $display("FAIL reset_pending got %0d exp 0", bus.pending_count);
        end
        checks++;
        if (bus.tag_err !== 1'b0) begin
            errors++; $display("FAIL reset_tag_err got %b exp 0", bus.tag_err);
        end
        checks++;
        if (bus.perf_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_perf got %0d exp 0", bus.perf_stall_cycles);
        end
    endtask

    // All four requesters valid: grants rotate 0,1,2,3,0 and slots go 0..4.
    task automatic test_round_robin();
        logic [3:0] exp_ready [5];
        exp_ready[0] = 4'b0001; exp_ready[1] = 4'b0010; exp_ready[2] = 4'b0100;
        exp_ready[3] = 4'b1000; exp_ready[4] = 4'b0001;
        do_reset();
        bus.req_valid     = 4'hF;
        bus.eng_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            int g;
            g = c % 4;
            #1;
            checks++;
            if (bus.req_ready !== exp_ready[c]) begin
                errors++; $display("FAIL rr_grant[%0d] got %b exp %b", c, bus.req_ready, exp_ready[c]);
            end
            checks++;
            if (bus.eng_req_tag !== 3'(c)) begin
                errors++; $display("FAIL rr_etag[%0d] got %0d exp %0d", c, bus.eng_req_tag, c);
            end
            checks++;
            if (bus.eng_req_src_addr !== 32'h1000 + g || bus.eng_req_dst_addr !== 32'h2000 + g ||
                bus.eng_req_size !== 16'(16 * (g + 1)) || bus.eng_req_to_lmem !== g[0]) begin
                errors++; $display("FAIL rr_payload[%0d] got %h/%h/%h/%b exp requester %0d", c,
                    bus.eng_req_src_addr, bus.eng_req_dst_addr, bus.eng_req_size, bus.eng_req_to_lmem, g);
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.pending_count !== 4'd5) begin
            errors++; $display("FAIL rr_pending got %0d exp 5", bus.pending_count);
        end
    endtask

    // Eight fires fill the table. Freeing slot 3 makes it the next engine tag.
    task automatic test_full();
        do_reset();
        fill(0, 8);
        bus.req_valid     = 4'h1;
        bus.eng_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.pending_count !== 4'd8) begin
            errors++; $display("FAIL full_pending got %0d exp 8", bus.pending_count);
        end
        checks++;
        if (bus.eng_req_valid !== 1'b0 || bus.req_ready !== 4'h0) begin
            errors++; $display("FAIL full_block got valid %b ready %h exp 0/0", bus.eng_req_valid, bus.req_ready);
        end
        bus.eng_req_ready = 1'b0;
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_tag   = 3'd3;
        bus.rsp_ready     = 4'hF;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.eng_rsp_ready !== 1'b1 || bus.rsp_tag[3:0] !== 4'h8) begin
            errors++; $display("FAIL full_rsp got rsp_valid %b ready %b tag %h exp 0001/1/8",
                bus.rsp_valid, bus.eng_rsp_ready, bus.rsp_tag[3:0]);
        end
        tick();
        bus.eng_rsp_valid = 1'b0;
        bus.eng_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.pending_count !== 4'd7 || bus.eng_req_valid !== 1'b1 || bus.eng_req_tag !== 3'd3) begin
            errors++; $display("FAIL full_reuse got pend %0d valid %b tag %0d exp 7/1/3",
                bus.pending_count, bus.eng_req_valid, bus.eng_req_tag);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.pending_count !== 4'd8) begin
            errors++; $display("FAIL full_refill got %0d exp 8", bus.pending_count);
        end
    endtask

    // Requester 2 (tag 0xA) lands in slot 5. Its completion waits on rsp_ready[2].
    task automatic test_route();
        do_reset();
        fill(0, 5);
        bus.req_valid     = 4'b0100;
        bus.eng_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.eng_req_tag !== 3'd5 || bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL route_alloc got tag %0d ready %b exp 5/0100", bus.eng_req_tag, bus.req_ready);
        end
        tick();
        idle_inputs();
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_tag   = 3'd5;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_tag[11:8] !== 4'hA || bus.eng_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL route_hold got valid %b tag %h ready %b exp 0100/a/0",
                bus.rsp_valid, bus.rsp_tag[11:8], bus.eng_rsp_ready);
        end
        tick();
        #1;
        checks++;
        if (bus.pending_count !== 4'd6 || bus.eng_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL route_wait got pend %0d ready %b exp 6/0", bus.pending_count, bus.eng_rsp_ready);
        end
        bus.rsp_ready = 4'b0100;
        #1;
        checks++;
        if (bus.eng_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL route_ready got %b exp 1", bus.eng_rsp_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.pending_count !== 4'd5) begin
            errors++; $display("FAIL route_free got %0d exp 5", bus.pending_count);
        end
    endtask

    // Allocate and free in the same cycle: the count stays put and the freed slot waits a cycle.
    task automatic test_same_cycle();
        do_reset();
        fill(0, 4);
        bus.req_valid     = 4'h1;
        bus.eng_req_ready = 1'b1;
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_tag   = 3'd1;
        bus.rsp_ready     = 4'hF;
        #1;
        checks++;
        if (bus.eng_req_tag !== 3'd4 || bus.eng_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL same_tag got %0d rsp_ready %b exp 4/1", bus.eng_req_tag, bus.eng_rsp_ready);
        end
        tick();
        bus.eng_rsp_valid = 1'b0;
        bus.eng_req_ready = 1'b0;
        #1;
        checks++;
        if (bus.pending_count !== 4'd4) begin
            errors++; $display("FAIL same_pending got %0d exp 4", bus.pending_count);
        end
        checks++;
        if (bus.eng_req_tag !== 3'd1) begin
            errors++; $display("FAIL same_reuse got %0d exp 1", bus.eng_req_tag);
        end
        idle_inputs();
    endtask

    // A completion for an empty slot is swallowed and tag_err sticks until reset.
    task automatic test_tag_err();
        do_reset();
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_tag   = 3'd6;
        bus.rsp_ready     = 4'h0;
        #1;
        checks++;
        if (bus.eng_rsp_ready !== 1'b1 || bus.rsp_valid !== 4'h0) begin
            errors++; $display("FAIL err_accept got ready %b valid %b exp 1/0000", bus.eng_rsp_ready, bus.rsp_valid);
        end
        tick();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (bus.tag_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b exp 1", bus.tag_err);
        end
        do_reset();
        #1;
        checks++;
        if (bus.tag_err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b exp 0", bus.tag_err);
        end
    endtask

    // Reset discards outstanding slots, so a late completion is flagged.
    task automatic test_reset_mid();
        do_reset();
        fill(1, 2);
        do_reset();
        bus.eng_rsp_valid = 1'b1;
        bus.eng_rsp_tag   = 3'd0;
        bus.rsp_ready     = 4'hF;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'h0 || bus.pending_count !== 4'd0) begin
            errors++; $display("FAIL mid_discard got valid %b pend %0d exp 0000/0", bus.rsp_valid, bus.pending_count);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.tag_err !== 1'b1) begin
            errors++; $display("FAIL mid_tag_err got %b exp 1", bus.tag_err);
        end
    endtask

    // Ten cycles of a waiting request with the engine not ready.
    task automatic test_perf();
        logic [31:0] exp_perf;
`ifdef DMA_ARB_PERF_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        do_reset();
        bus.req_valid     = 4'h4;
        bus.eng_req_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        idle_inputs();
        tick();
        checks++;
        if (bus.perf_stall_cycles !== exp_perf) begin
            errors++; $display("FAIL perf_count got %0d exp %0d", bus.perf_stall_cycles, exp_perf);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        set_payloads();
        test_reset();
        test_round_robin();
        test_full();
        test_route();
        test_same_cycle();
        test_tag_err();
        test_reset_mid();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // backstop so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule
